// File: rtl/ro_meas_sequencer.sv
// ro_meas_sequencer
// Measurement sequencer for the ring-oscillator temperature sensor.
// A command byte from the UART RX selects the inverter RO (0x00) or the
// NAND RO (0x01). The block warms the oscillator up, gates the RO edge
// counter for WINDOW_CYCLES clocks, holds for counter synchronisation,
// captures the count, and returns it MSB first to the UART TX.
// Any other command byte returns the error byte 0xEE with no oscillator
// activity.
//
// Optional feature: define MEAS_CHECKSUM_EN to append one XOR checksum
// byte to every frame (the error frame becomes 0xEE, 0xEE).
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid, cmd_data   one-cycle command strobe and byte
//   tx_valid, tx_data     byte offered to the UART TX
//   tx_ready              UART TX accepts the byte this cycle
//   osc_sel               0 = inverter RO, 1 = NAND RO
//   en_inv_osc            inverter RO enable
//   en_nand_osc           NAND RO enable
//   cnt_clear             synchronous clear request to the RO counter
//   cnt_enable            RO counter gate
//   ro_count              RO counter value, stable during HOLD
//   busy                  high in every state except IDLE
//   state_dbg             current FSM state, for observation only
//
// TX handshake: a byte transfers on a clock edge where tx_valid and
// tx_ready are both high; tx_valid/tx_data stay stable until then, the
// next byte is presented the cycle after a transfer, and tx_valid and
// busy both drop the cycle after the final byte transfers.
module ro_meas_sequencer #(
  parameter int WINDOW_CYCLES = 4096,
  parameter int SETTLE_CYCLES = 16,
  parameter int COUNT_W       = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  input  logic [7:0]         cmd_data,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               osc_sel,
  output logic               en_inv_osc,
  output logic               en_nand_osc,
  output logic               cnt_clear,
  output logic               cnt_enable,
  input  logic [COUNT_W-1:0] ro_count,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    GATE   = 3'd2,
    HOLD   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam int MAX_CYC    = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYC) + 1;
  localparam int DATA_BYTES = COUNT_W / 8;
`ifdef MEAS_CHECKSUM_EN
  localparam int FRAME_BYTES = DATA_BYTES + 1;
  localparam int ERR_BYTES   = 2;
`else
  localparam int FRAME_BYTES = DATA_BYTES;
  localparam int ERR_BYTES   = 1;
`endif
  localparam int IDX_W = $clog2(FRAME_BYTES + 1) + 1;

  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] DATA_LAST   = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] ERR_LAST    = IDX_W'(ERR_BYTES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [COUNT_W-1:0] send_sr;   // shadow of ro_count, shifted left per byte sent
  logic [COUNT_W-1:0] sr_next;
  logic [IDX_W-1:0]   byte_idx;
  logic               err;
`ifdef MEAS_CHECKSUM_EN
  logic [7:0]         csum;

  function automatic logic [7:0] xor_bytes(input logic [COUNT_W-1:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) acc = acc ^ v[8*i +: 8];
    return acc;
  endfunction
`endif

  assign sr_next   = send_sr << 8;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      send_sr     <= '0;
      byte_idx    <= '0;
      err         <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      osc_sel     <= 1'b0;
      en_inv_osc  <= 1'b0;
      en_nand_osc <= 1'b0;
      cnt_clear   <= 1'b0;
      cnt_enable  <= 1'b0;
      busy        <= 1'b0;
`ifdef MEAS_CHECKSUM_EN
      csum        <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            busy     <= 1'b1;
            cnt      <= '0;
            byte_idx <= '0;
            if (cmd_data[7:1] == 7'd0) begin
              state       <= WARMUP;
              osc_sel     <= cmd_data[0];
              en_inv_osc  <= ~cmd_data[0];
              en_nand_osc <= cmd_data[0];
              cnt_clear   <= 1'b1;
            end else begin
              // Error frame goes straight out; oscillators stay off.
              state    <= SEND;
              err      <= 1'b1;
              tx_valid <= 1'b1;
              tx_data  <= 8'hEE;
`ifdef MEAS_CHECKSUM_EN
              csum     <= 8'hEE;
`endif
            end
          end
        end
        WARMUP: begin
          if (cnt == SET_LAST) begin
            cnt        <= '0;
            state      <= GATE;
            cnt_clear  <= 1'b0;
            cnt_enable <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GATE: begin
          if (cnt == WIN_LAST) begin
            cnt         <= '0;
            state       <= HOLD;
            cnt_enable  <= 1'b0;
            en_inv_osc  <= 1'b0;
            en_nand_osc <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == SET_LAST) begin
            // Capture on the last HOLD cycle, after the counter has settled.
            cnt      <= '0;
            state    <= SEND;
            send_sr  <= ro_count;
            tx_valid <= 1'b1;
            tx_data  <= ro_count[COUNT_W-1 -: 8];
`ifdef MEAS_CHECKSUM_EN
            csum     <= xor_bytes(ro_count);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (byte_idx == (err ? ERR_LAST : DATA_LAST)) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              send_sr  <= sr_next;
`ifdef MEAS_CHECKSUM_EN
              if (err || byte_idx == IDX_W'(DATA_BYTES - 1)) tx_data <= csum;
              else                                            tx_data <= sr_next[COUNT_W-1 -: 8];
`else
              tx_data  <= sr_next[COUNT_W-1 -: 8];
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Bench for ro_meas_sequencer with default parameters: directed scenarios
// plus randomized commands/counts/backpressure, checked against a frame
// model and per-run cycle counts derived from the command timing rules.
module tb_ro_meas_sequencer;
  localparam int W  = 4096;
  localparam int S  = 16;
  localparam int CW = 24;
  localparam int NB = CW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          osc_sel;
  logic          en_inv_osc;
  logic          en_nand_osc;
  logic          cnt_clear;
  logic          cnt_enable;
  logic [CW-1:0] ro_count;
  logic          busy;
  logic [2:0]    state_dbg;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    exp_q[$];
  logic [CW-1:0] target = '0;
  logic          last_sel = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ro_meas_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .osc_sel(osc_sel), .en_inv_osc(en_inv_osc), .en_nand_osc(en_nand_osc),
    .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .ro_count(ro_count),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Counter stand-in: garbage while gated, the intended result otherwise.
  always @(posedge clk) begin
    #1;
    if (cnt_enable) ro_count = CW'($urandom);
    else            ro_count = target;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_expected(input logic [7:0] cmd, input logic [CW-1:0] val);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    if (cmd <= 8'h01) begin
      for (int i = 0; i < NB; i++) begin
        b = 8'((val >> (8 * (NB - 1 - i))) & 'hFF);
        cs = cs ^ b;
        exp_q.push_back(b);
      end
`ifdef MEAS_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
    end else begin
      exp_q.push_back(8'hEE);
`ifdef MEAS_CHECKSUM_EN
      exp_q.push_back(8'hEE);
`endif
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic       prev_valid = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (prev_valid && !prev_xfer) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", tx_data, $time);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = tx_valid;
      prev_data  = tx_data;
      prev_xfer  = tx_valid && tx_ready;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic issue_cmd(input logic [7:0] cmd, input logic [CW-1:0] val);
    target = val;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    push_expected(cmd, val);
    @(posedge clk); #1;   // command sampled; now first cycle after it
    cmd_valid = 1'b0;
    if (cmd <= 8'h01) last_sel = cmd[0];
  endtask

  task automatic run_meas(input logic [7:0] cmd, input logic [CW-1:0] val,
                          input bit stall, input bit inject);
    int  t, first_tx, n_gate, n_inv, n_nand, n_both, sel_err, waitc;
    bit  meas;
    meas = (cmd <= 8'h01);
    issue_cmd(cmd, val);
    t = 1; first_tx = -1; n_gate = 0; n_inv = 0; n_nand = 0;
    n_both = 0; sel_err = 0; waitc = 0;
    check("busy_rise", 32'(busy), 32'd1);
    while (busy && t < 20000) begin
      if (tx_valid && first_tx < 0) first_tx = t;
      if (cnt_enable)  n_gate++;
      if (en_inv_osc)  n_inv++;
      if (en_nand_osc) n_nand++;
      if (en_inv_osc && en_nand_osc) n_both++;
      if (osc_sel !== last_sel) sel_err++;
      cmd_valid = inject && (t == S + 100);
      cmd_data  = 8'h01;
      if (stall) begin
        if (tx_valid && waitc >= 10) begin
          tx_ready = 1'b1;
          waitc = 0;
        end else begin
          tx_ready = 1'b0;
          if (tx_valid) waitc++;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    check("busy_fall", 32'(busy), 32'd0);
    check("tx_valid_end", 32'(tx_valid), 32'd0);
    check("first_tx_cycle", 32'(first_tx), meas ? 32'(1 + 2 * S + W) : 32'd1);
    check("cnt_enable_cycles", 32'(n_gate), meas ? 32'(W) : 32'd0);
    check("en_inv_cycles", 32'(n_inv), (meas && !cmd[0]) ? 32'(S + W) : 32'd0);
    check("en_nand_cycles", 32'(n_nand), (meas && cmd[0]) ? 32'(S + W) : 32'd0);
    check("en_both", 32'(n_both), 32'd0);
    check("osc_sel_track", 32'(sel_err), 32'd0);
    check("frame_complete", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_osc_sel"}, 32'(osc_sel), 32'd0);
    check({tag, "_en_inv"}, 32'(en_inv_osc), 32'd0);
    check({tag, "_en_nand"}, 32'(en_nand_osc), 32'd0);
    check({tag, "_cnt_clear"}, 32'(cnt_clear), 32'd0);
    check({tag, "_cnt_enable"}, 32'(cnt_enable), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rc;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    tx_ready  = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #2;
    reset_n = 1'b1;

    run_meas(8'h00, 24'h012345, 1'b0, 1'b0);     // inverter
    run_meas(8'h01, 24'hABCDEF, 1'b0, 1'b0);     // NAND
    run_meas(8'h7F, CW'($urandom), 1'b0, 1'b0);  // bad command
    run_meas(8'h00, CW'($urandom), 1'b0, 1'b1);  // command during GATE dropped
    run_meas(8'h00, CW'($urandom), 1'b1, 1'b0);  // backpressure
    run_meas(8'hC3, CW'($urandom), 1'b1, 1'b0);  // backpressure on error frame

    // Reset at GATE cycle 100.
    issue_cmd(8'h01, CW'($urandom));
    repeat (S + 99) @(posedge clk);
    #3;
    check("pre_reset_gate", 32'(cnt_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    last_sel = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_after_reset", 32'(busy), 32'd0);
    run_meas(8'h00, CW'($urandom), 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0: rc = 8'h00;
        1: rc = 8'h01;
        default: rc = 8'($urandom_range(2, 255));
      endcase
      run_meas(rc, CW'($urandom), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
